// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - instruction fetch stage: PC-to-memory request handshake plus tagged instruction FIFO
//
// Purpose: accepts the PC address, issues one outstanding memory request at a
// time, queues returned instructions with their address for the decoder, and
// holds the PC (pc_halt_o) until its address has been accepted. flush_i drops
// every stale fetch, both the queued ones and the one in flight.
//
// Ports:
//   clk_i, n_rst_i          clock (rising edge), asynchronous active-low reset
//   pc_addr_i, pc_halt_o    PC address in, PC hold out (0 = PC may update)
//   flush_i                 decode redirect
//   mem_req_o, mem_addr_o   memory request, held until mem_ack_i
//   mem_ack_i, mem_rdata_i  memory completion and instruction data
//   instr_valid_o, instr_o, instr_addr_o, instr_ready_i   decoder stream
module fetch_buffer #(
  parameter int A     = 8,
  parameter int N     = 16,
  parameter int DEPTH = 2
) (
  input  logic         clk_i,
  input  logic         n_rst_i,
  input  logic [A-1:0] pc_addr_i,
  output logic         pc_halt_o,
  input  logic         flush_i,
  output logic         mem_req_o,
  output logic [A-1:0] mem_addr_o,
  input  logic         mem_ack_i,
  input  logic [N-1:0] mem_rdata_i,
  output logic         instr_valid_o,
  output logic [N-1:0] instr_o,
  output logic [A-1:0] instr_addr_o,
  input  logic         instr_ready_i
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0]   DEPTH_C = (CW + 1)'(DEPTH);
  localparam logic [PW-1:0] LAST_P  = PW'(DEPTH - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_DISCARD = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [A-1:0]  addr_q;
  logic [N-1:0]  data_mem [DEPTH];
  logic [A-1:0]  tag_mem  [DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q;

  logic          in_idle, in_req;
  logic          pop, push, accept;
  logic [CW:0]   reserved, committed;

  assign in_idle = (state_q == ST_IDLE);
  assign in_req  = (state_q == ST_REQ);

  assign pop  = (count_q != '0) & instr_ready_i & ~flush_i;
  assign push = in_req & mem_ack_i & ~flush_i;

  // A kept request already owns a FIFO slot, so it is counted before a new
  // address is accepted; this is what keeps the FIFO from overflowing.
  assign reserved  = {1'b0, count_q} + {{CW{1'b0}}, in_req};
  assign committed = reserved - {{CW{1'b0}}, pop};
  assign accept    = ~flush_i & (in_idle | (in_req & mem_ack_i)) & (committed < DEPTH_C);

  // During reset the PC must not advance even though the state reads IDLE.
  assign pc_halt_o = ~n_rst_i | ~(accept | flush_i);

  assign mem_req_o     = ~in_idle;
  assign mem_addr_o    = addr_q;
  assign instr_valid_o = (count_q != '0);
  assign instr_o       = data_mem[rd_ptr_q];
  assign instr_addr_o  = tag_mem[rd_ptr_q];

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_P) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (flush_i)        state_d = mem_ack_i ? ST_IDLE : ST_DISCARD;
        else if (mem_ack_i) state_d = accept ? ST_REQ : ST_IDLE;
      end
      ST_DISCARD: begin
        if (mem_ack_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) addr_q <= pc_addr_i;
    end
  end

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      if (push & ~pop)      count_q <= count_q + CW'(1);
      else if (~push & pop) count_q <= count_q - CW'(1);
    end
  end

  // Entries are tagged with the request address, not the live PC address.
  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_mem[i] <= '0;
        tag_mem[i]  <= '0;
      end
    end else if (push) begin
      data_mem[wr_ptr_q] <= mem_rdata_i;
      tag_mem[wr_ptr_q]  <= addr_q;
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// tb/tb_fetch_buffer.sv - self-checking bench for fetch_buffer
module tb_fetch_buffer;

  logic        clk_i = 1'b0;
  logic        n_rst_i = 1'b0;
  logic [7:0]  pc_addr_i = '0;
  logic        pc_halt_o;
  logic        flush_i = 1'b0;
  logic        mem_req_o;
  logic [7:0]  mem_addr_o;
  logic        mem_ack_i = 1'b0;
  logic [15:0] mem_rdata_i = '0;
  logic        instr_valid_o;
  logic [15:0] instr_o;
  logic [7:0]  instr_addr_o;
  logic        instr_ready_i = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_buffer #(.A(8), .N(16), .DEPTH(2)) dut (
    .clk_i(clk_i), .n_rst_i(n_rst_i), .pc_addr_i(pc_addr_i), .pc_halt_o(pc_halt_o),
    .flush_i(flush_i), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i), .instr_valid_o(instr_valid_o),
    .instr_o(instr_o), .instr_addr_o(instr_addr_o), .instr_ready_i(instr_ready_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Asserts reset, checks reset outputs, releases on the next falling edge.
  task automatic do_reset();
    n_rst_i = 1'b0;
    #1;
    chk("rst_halt",  32'(pc_halt_o), 1);
    chk("rst_req",   32'(mem_req_o), 0);
    chk("rst_maddr", 32'(mem_addr_o), 0);
    chk("rst_valid", 32'(instr_valid_o), 0);
    chk("rst_instr", 32'(instr_o), 0);
    chk("rst_iaddr", 32'(instr_addr_o), 0);
    @(negedge clk_i);
    n_rst_i = 1'b1;
  endtask

  typedef struct {
    bit         rst, flush, ack, ready;
    logic [7:0] pc;
    bit         halt, req;
    logic [7:0] maddr;
    bit         valid;
    logic [7:0] iaddr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(bit rst, bit fl, bit ack, bit rdy, logic [7:0] pc,
                             bit halt, bit req, logic [7:0] maddr, bit valid, logic [7:0] iaddr);
    vec_t r;
    r.rst = rst; r.flush = fl; r.ack = ack; r.ready = rdy; r.pc = pc;
    r.halt = halt; r.req = req; r.maddr = maddr; r.valid = valid; r.iaddr = iaddr;
    return r;
  endfunction

  // Reference model: one in-flight request flag, a drop flag and a queue.
  typedef struct { logic [15:0] d; logic [7:0] a; } ent_t;
  ent_t       mq[$];
  bit         m_out, m_drop;
  logic [7:0] m_areg, pc;

  initial begin
    // streaming, ack every cycle
    tbl.push_back(v(1,0,1,1,8'h00, 0,0,8'h00,0,8'h00));
    tbl.push_back(v(0,0,1,1,8'h01, 0,1,8'h00,0,8'h00));
    tbl.push_back(v(0,0,1,1,8'h02, 0,1,8'h01,1,8'h00));
    tbl.push_back(v(0,0,1,1,8'h03, 0,1,8'h02,1,8'h01));
    tbl.push_back(v(0,0,1,1,8'h04, 0,1,8'h03,1,8'h02));
    // decoder stalled, FIFO fills, one pop
    tbl.push_back(v(1,0,1,0,8'h00, 0,0,8'h00,0,8'h00));
    tbl.push_back(v(0,0,1,0,8'h01, 0,1,8'h00,0,8'h00));
    tbl.push_back(v(0,0,1,0,8'h02, 1,1,8'h01,1,8'h00));
    tbl.push_back(v(0,0,1,0,8'h02, 1,0,8'h01,1,8'h00));
    tbl.push_back(v(0,0,1,1,8'h02, 0,0,8'h01,1,8'h00));
    tbl.push_back(v(0,0,1,0,8'h03, 1,1,8'h02,1,8'h01));
    tbl.push_back(v(0,0,1,0,8'h03, 1,0,8'h02,1,8'h01));
    // slow ack for addr 4
    tbl.push_back(v(1,0,0,1,8'h04, 0,0,8'h00,0,8'h00));
    tbl.push_back(v(0,0,0,1,8'h05, 1,1,8'h04,0,8'h00));
    tbl.push_back(v(0,0,0,1,8'h05, 1,1,8'h04,0,8'h00));
    tbl.push_back(v(0,0,0,1,8'h05, 1,1,8'h04,0,8'h00));
    tbl.push_back(v(0,0,1,1,8'h05, 0,1,8'h04,0,8'h00));
    tbl.push_back(v(0,0,0,1,8'h06, 1,1,8'h05,1,8'h04));
    tbl.push_back(v(0,0,0,1,8'h06, 1,1,8'h05,0,8'h00));
    // flush while waiting, redirect to 0x20
    tbl.push_back(v(1,0,0,1,8'h05, 0,0,8'h00,0,8'h00));
    tbl.push_back(v(0,1,0,1,8'h05, 0,1,8'h05,0,8'h00));
    tbl.push_back(v(0,0,0,1,8'h20, 1,1,8'h05,0,8'h00));
    tbl.push_back(v(0,0,1,1,8'h20, 1,1,8'h05,0,8'h00));
    tbl.push_back(v(0,0,0,1,8'h20, 0,0,8'h05,0,8'h00));
    tbl.push_back(v(0,0,1,1,8'h21, 0,1,8'h20,0,8'h00));
    tbl.push_back(v(0,0,0,1,8'h22, 1,1,8'h21,1,8'h20));
    // flush together with ack, one entry queued
    tbl.push_back(v(1,0,1,0,8'h00, 0,0,8'h00,0,8'h00));
    tbl.push_back(v(0,0,1,0,8'h01, 0,1,8'h00,0,8'h00));
    tbl.push_back(v(0,1,1,0,8'h02, 0,1,8'h01,1,8'h00));
    tbl.push_back(v(0,0,0,0,8'h40, 0,0,8'h01,0,8'h00));
    tbl.push_back(v(0,0,0,0,8'h41, 1,1,8'h40,0,8'h00));

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) do_reset();
      else @(negedge clk_i);
      flush_i       = tbl[i].flush;
      mem_ack_i     = tbl[i].ack;
      instr_ready_i = tbl[i].ready;
      pc_addr_i     = tbl[i].pc;
      mem_rdata_i   = {8'hD0, mem_addr_o};
      #1;
      chk($sformatf("v%0d_halt", i),  32'(pc_halt_o), 32'(tbl[i].halt));
      chk($sformatf("v%0d_req", i),   32'(mem_req_o), 32'(tbl[i].req));
      chk($sformatf("v%0d_maddr", i), 32'(mem_addr_o), 32'(tbl[i].maddr));
      chk($sformatf("v%0d_valid", i), 32'(instr_valid_o), 32'(tbl[i].valid));
      if (tbl[i].valid) begin
        chk($sformatf("v%0d_iaddr", i), 32'(instr_addr_o), 32'(tbl[i].iaddr));
        chk($sformatf("v%0d_instr", i), 32'(instr_o), {16'h0, 8'hD0, tbl[i].iaddr});
      end
    end

    // reset in the middle of an outstanding request
    do_reset();
    flush_i = 0; mem_ack_i = 1; instr_ready_i = 0; pc_addr_i = 8'h00;
    @(negedge clk_i); pc_addr_i = 8'h01; mem_rdata_i = 16'h1234;
    @(negedge clk_i); pc_addr_i = 8'h02; mem_ack_i = 0;
    #1;
    chk("mid_pre_req",   32'(mem_req_o), 1);
    chk("mid_pre_valid", 32'(instr_valid_o), 1);
    #2;
    n_rst_i = 1'b0;
    #1;
    chk("mid_req",   32'(mem_req_o), 0);
    chk("mid_valid", 32'(instr_valid_o), 0);
    chk("mid_halt",  32'(pc_halt_o), 1);
    mem_ack_i = 1;
    @(negedge clk_i);
    n_rst_i = 1'b1; mem_ack_i = 0; pc_addr_i = 8'h00;
    #1;
    chk("post_halt", 32'(pc_halt_o), 0);
    chk("post_req",  32'(mem_req_o), 0);
    @(negedge clk_i); pc_addr_i = 8'h01;
    #1;
    chk("post_req2",   32'(mem_req_o), 1);
    chk("post_maddr2", 32'(mem_addr_o), 0);
    chk("post_valid2", 32'(instr_valid_o), 0);

    // randomized run against the queue model
    do_reset();
    mq.delete(); m_out = 0; m_drop = 0; m_areg = '0; pc = '0;
    for (int c = 0; c < 3000; c++) begin
      bit         fl, ack, rdy, e_valid, e_pop, e_acc, e_halt;
      int         resv;
      logic [7:0] tgt;
      if (c != 0) @(negedge clk_i);
      fl  = ($urandom_range(0, 9) == 0);
      ack = ($urandom_range(0, 1) == 1);
      rdy = ($urandom_range(0, 9) < 6);
      tgt = 8'($urandom);
      flush_i = fl; mem_ack_i = ack; instr_ready_i = rdy;
      pc_addr_i = pc; mem_rdata_i = 16'($urandom);
      e_valid = (mq.size() != 0);
      e_pop   = e_valid & rdy & ~fl;
      resv    = mq.size() + ((m_out && !m_drop) ? 1 : 0);
      e_acc   = !fl && (!m_out || (m_out && !m_drop && ack)) && (resv - int'(e_pop) < 2);
      e_halt  = !(e_acc || fl);
      #1;
      chk("r_halt",  32'(pc_halt_o), 32'(e_halt));
      chk("r_req",   32'(mem_req_o), 32'(m_out));
      chk("r_maddr", 32'(mem_addr_o), 32'(m_areg));
      chk("r_valid", 32'(instr_valid_o), 32'(e_valid));
      if (e_valid) begin
        chk("r_iaddr", 32'(instr_addr_o), 32'(mq[0].a));
        chk("r_instr", 32'(instr_o), 32'(mq[0].d));
      end
      if (fl) begin
        mq.delete();
        if (m_out) begin
          if (ack) begin m_out = 0; m_drop = 0; end
          else m_drop = 1;
        end
      end else begin
        if (m_out && ack) begin
          if (!m_drop) mq.push_back('{d: mem_rdata_i, a: m_areg});
          m_out = 0; m_drop = 0;
        end
        if (e_pop) void'(mq.pop_front());
        if (e_acc) begin m_areg = pc; m_out = 1; m_drop = 0; end
      end
      pc = fl ? tgt : (e_halt ? pc : pc + 8'd1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
